// File: rtl/uart_echo_pkg.sv
// uart_echo_pkg: shared counter width, saturation value and saturating increment.
package uart_echo_pkg;
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        return (en && c != CNT_MAX) ? c + 1'b1 : c;
    endfunction
endpackage

// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo: DEPTH-entry storage with wrapping pointers and an occupancy count.
// The caller guarantees push never overflows and pop never underflows.
module uart_echo_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_WIDTH-1:0]      wdata,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;

    // Storage is not reset; only entries below level are ever observed.
    always_ff @(posedge clk)
        if (push && !flush) mem[wr_ptr] <= wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            level <= (push && !pop) ? level + 1'b1 : (pop && !push) ? level - 1'b1 : level;
        end
    end

    assign rdata = mem[rd_ptr];
endmodule

// File: rtl/uart_echo_buf.sv
// uart_echo_buf: UART echo FIFO with drop-on-full or backpressure, flush and loss counters.
// Define UART_ECHO_STATS_EN to add the ferr_cnt frame-error counter port.
module uart_echo_buf
    import uart_echo_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 16,
    parameter int DROP_ON_FULL = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tuser,
    output logic [DATA_WIDTH-1:0]      m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [CNT_W-1:0]           drop_cnt
`ifdef UART_ECHO_STATS_EN
    ,
    output logic [CNT_W-1:0]           ferr_cnt
`endif
);
    localparam int LW = $clog2(DEPTH+1);

    logic full, pop, acc, push, drop;

    assign full          = level == LW'(DEPTH);
    assign m_axis_tvalid = level != '0;
    assign s_axis_tready = rst_n && (DROP_ON_FULL != 0 || !full);
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign acc           = s_axis_tvalid && s_axis_tready;
    // A full buffer still takes a beat when the same edge frees a slot.
    assign push          = acc && !s_axis_tuser && (!full || pop);
    assign drop          = acc && !s_axis_tuser && full && !pop;

    uart_echo_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata (s_axis_tdata),
        .rdata (m_axis_tdata),
        .level (level)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) drop_cnt <= '0;
        else drop_cnt <= sat_inc(drop_cnt, drop);

`ifdef UART_ECHO_STATS_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ferr_cnt <= '0;
        else ferr_cnt <= sat_inc(ferr_cnt, acc && s_axis_tuser);
`endif
endmodule

// File: tb/tb_uart_echo_buf.sv
// tb_uart_echo_buf: directed table plus corner sequences for drop-on-full and backpressure builds.
// Frame-error counter checks are included when UART_ECHO_STATS_EN is defined.
module tb_uart_echo_buf;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] d_sd, d_md, b_sd, b_md;
    logic d_sv, d_su, d_sr, d_mv, d_mr, d_fl;
    logic b_sv, b_su, b_sr, b_mv, b_mr, b_fl;
    logic [2:0] d_lvl, b_lvl;
    logic [15:0] d_dc, b_dc;
`ifdef UART_ECHO_STATS_EN
    logic [15:0] d_fc, b_fc;
`endif

    uart_echo_buf #(.DATA_WIDTH(8), .DEPTH(4), .DROP_ON_FULL(1)) dut_d (
        .clk(clk), .rst_n(rst_n), .s_axis_tdata(d_sd), .s_axis_tvalid(d_sv),
        .s_axis_tready(d_sr), .s_axis_tuser(d_su), .m_axis_tdata(d_md),
        .m_axis_tvalid(d_mv), .m_axis_tready(d_mr), .flush(d_fl), .level(d_lvl),
        .drop_cnt(d_dc)
`ifdef UART_ECHO_STATS_EN
        , .ferr_cnt(d_fc)
`endif
    );

    uart_echo_buf #(.DATA_WIDTH(8), .DEPTH(4), .DROP_ON_FULL(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_axis_tdata(b_sd), .s_axis_tvalid(b_sv),
        .s_axis_tready(b_sr), .s_axis_tuser(b_su), .m_axis_tdata(b_md),
        .m_axis_tvalid(b_mv), .m_axis_tready(b_mr), .flush(b_fl), .level(b_lvl),
        .drop_cnt(b_dc)
`ifdef UART_ECHO_STATS_EN
        , .ferr_cnt(b_fc)
`endif
    );

    typedef struct {
        logic v; logic [7:0] d; logic u; logic r; logic f;
        logic [2:0] lvl; logic mv; logic [7:0] md; logic [15:0] dc;
    } vec_t;

    vec_t vt[$];
    int total = 0, bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [7:0] d, input logic u, input logic r, input logic f,
                       input logic [2:0] lvl, input logic mv, input logic [7:0] md, input logic [15:0] dc);
        vec_t x;
        x.v = v; x.d = d; x.u = u; x.r = r; x.f = f;
        x.lvl = lvl; x.mv = mv; x.md = md; x.dc = dc;
        vt.push_back(x);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_b [4];
        d_sd = 8'h00; d_sv = 1'b0; d_su = 1'b0; d_mr = 1'b0; d_fl = 1'b0;
        b_sd = 8'h00; b_sv = 1'b0; b_su = 1'b0; b_mr = 1'b0; b_fl = 1'b0;

        //   v     d       u     r     f     lvl   mv    md      dc
        add(1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 8'h41, 16'd0);
        add(1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 8'h41, 16'd0);
        add(1'b1, 8'h43, 1'b0, 1'b1, 1'b0, 3'd2, 1'b1, 8'h42, 16'd0);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 8'h43, 16'd0);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 16'd0);
        add(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 16'd0);
        add(1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 8'h66, 16'd0);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 16'd0);
        add(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 8'h01, 16'd0);
        add(1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 8'h01, 16'd0);
        add(1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 8'h01, 16'd0);
        add(1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 8'h01, 16'd0);
        add(1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 8'h01, 16'd1);
        add(1'b1, 8'h06, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 8'h01, 16'd2);
        add(1'b1, 8'h07, 1'b0, 1'b1, 1'b0, 3'd4, 1'b1, 8'h02, 16'd2);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 8'h03, 16'd2);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd2, 1'b1, 8'h04, 16'd2);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 8'h07, 16'd2);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 16'd2);
        add(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 8'hA1, 16'd2);
        add(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 8'hA1, 16'd2);
        add(1'b1, 8'hA3, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 8'hA1, 16'd2);
        add(1'b1, 8'hA4, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 8'h00, 16'd2);
        add(1'b1, 8'hB1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 8'hB1, 16'd2);

        // Reset state
        #12;
        chk("rst_level", int'(d_lvl), 0);
        chk("rst_mvalid", int'(d_mv), 0);
        chk("rst_sready_drop", int'(d_sr), 0);
        chk("rst_sready_bp", int'(b_sr), 0);
        chk("rst_drop_cnt", int'(d_dc), 0);
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("sready_drop_idle", int'(d_sr), 1);
        chk("sready_bp_idle", int'(b_sr), 1);
        chk("mvalid_before_push", int'(d_mv), 0);

        foreach (vt[i]) begin
            @(negedge clk);
            d_sv = vt[i].v; d_sd = vt[i].d; d_su = vt[i].u; d_mr = vt[i].r; d_fl = vt[i].f;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_level", i), int'(d_lvl), int'(vt[i].lvl));
            chk($sformatf("v%0d_mvalid", i), int'(d_mv), int'(vt[i].mv));
            if (vt[i].mv) chk($sformatf("v%0d_mdata", i), int'(d_md), int'(vt[i].md));
            chk($sformatf("v%0d_drop_cnt", i), int'(d_dc), int'(vt[i].dc));
            chk($sformatf("v%0d_sready", i), int'(d_sr), 1);
        end
        @(negedge clk);
        d_sv = 1'b0; d_su = 1'b0; d_mr = 1'b0; d_fl = 1'b0;
`ifdef UART_ECHO_STATS_EN
        chk("ferr_cnt", int'(d_fc), 1);
`endif

        // Backpressure: fill, one-cycle pop pulse, stalled beat must land afterwards
        b_sv = 1'b1; b_mr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b_sd = 8'h10 + 8'(i);
            @(posedge clk);
            @(negedge clk);
        end
        chk("bp_full_level", int'(b_lvl), 4);
        chk("bp_full_sready", int'(b_sr), 0);
        chk("bp_hold_mdata", int'(b_md), 'h10);
        b_sd = 8'h99; b_mr = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_pulse_sready", int'(b_sr), 1);
        chk("bp_pulse_level", int'(b_lvl), 3);
        chk("bp_pulse_mdata", int'(b_md), 'h11);
        @(negedge clk) b_mr = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_refill_level", int'(b_lvl), 4);
        chk("bp_refill_sready", int'(b_sr), 0);
        @(negedge clk);
        b_sv = 1'b0; b_mr = 1'b1;
        exp_b = '{8'h11, 8'h12, 8'h13, 8'h99};
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bp_drain%0d_mvalid", k), int'(b_mv), 1);
            chk($sformatf("bp_drain%0d_mdata", k), int'(b_md), int'(exp_b[k]));
            @(negedge clk);
        end
        chk("bp_empty_mvalid", int'(b_mv), 0);
        chk("bp_drop_cnt", int'(b_dc), 0);
        b_mr = 1'b0;

        // Asynchronous reset mid-stream, away from any edge
        @(negedge clk) d_sv = 1'b1; d_sd = 8'hC1;
        @(negedge clk) d_sv = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_level", int'(d_lvl), 0);
        chk("arst_mvalid", int'(d_mv), 0);
        chk("arst_sready", int'(d_sr), 0);
        chk("arst_drop_cnt", int'(d_dc), 0);
        chk("arst_bp_sready", int'(b_sr), 0);
`ifdef UART_ECHO_STATS_EN
        chk("arst_ferr_cnt", int'(d_fc), 0);
`endif
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk) d_sv = 1'b1; d_sd = 8'h77;
        @(posedge clk);
        #1;
        chk("post_rst_level", int'(d_lvl), 1);
        chk("post_rst_mdata", int'(d_md), 'h77);
        d_sv = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
